huff_decoder: RTL and testbench
===============================

# huff_decoder

Serial Huffman decoder that pairs with `huff_encoder`.

- It loads a code table of `MAX_CHAR_COUNT` entries over the same 12-bit `io_in` pin bus. Each entry is a character word followed by a mask/value code word, in the order the encoder emits them.
- It then consumes an encoded bitstream one bit per accepted word and emits each decoded 8-bit character as a one-cycle strobe on `io_out`.
- It sits on the receive side of the pin-limited encoder/decoder pair and shares its 12-bit in / 12-bit out pin budget.

## Interface

- `MAX_CHAR_COUNT`, default 3: number of table entries loaded per vector.
- `CODE_W`, default 4: maximum code length in bits; also the width of the mask and value fields.
- `clk`  input  1  clock.
- `reset`  input  1  reset, synchronous, active-high; clock `clk`.
- `io_in`  input  12  command word:
  - `[11]` valid.
  - `[10:9]` cmd: 00 = char, 01 = code, 10 = bit, 11 = flush.
  - `[8]` reserved, must be 0.
  - `[7:0]` payload.
- `io_out`  output  12  status/data:
  - `[11]` done pulse.
  - `[10]` table_ready.
  - `[9]` error.
  - `[8]` char valid pulse.
  - `[7:0]` decoded character.

## Operation

- Code word payload: `[7:4]` = mask, `[3:0]` = value.
  - Mask must be a nonzero LSB-aligned thermometer: 0001, 0011, 0111 or 1111.
  - Code length L = popcount(mask).
  - Bits are transmitted MSB of the valid field first, so value bit L-1 is sent first and bit 0 last.
- States: LOAD_CHAR, LOAD_CODE, DECODE, ERROR.
- LOAD_CHAR:
  - cmd 00 stores `char[idx]` and moves to LOAD_CODE.
  - Any other valid cmd moves to ERROR, except flush (see below).
- LOAD_CODE:
  - cmd 01 with a legal mask stores `mask[idx]` and `val[idx]`.
  - If `idx == MAX_CHAR_COUNT-1`: `idx` clears and the state moves to DECODE, with table_ready set. Otherwise `idx` increments and the state moves to LOAD_CHAR.
  - An illegal mask or wrong cmd moves to ERROR.
- DECODE: cmd 10 shifts `io_in[0]` into `shreg` (`CODE_W` bits, `shreg <= {shreg[CODE_W-2:0], bit}`) and increments `len`. Match is evaluated on the post-shift `shreg`/`len`:
  - Entry k matches if `len == popcount(mask[k])` and `(shreg & mask[k]) == val[k]`.
  - If several entries match, the lowest k wins.
  - On a match: `io_out[7:0] <= char[k]`, `io_out[8]` pulses, and `shreg` and `len` clear.
  - No match with `len == CODE_W` moves to ERROR.
  - cmd 00 or 01 in DECODE moves to ERROR.
- Flush (cmd 11):
  - In DECODE with `len == 0`: `io_out[11]` pulses, the table is invalidated (table_ready clears) and the state moves to LOAD_CHAR, ready for the next vector.
  - In DECODE with `len != 0`: moves to ERROR.
  - In LOAD_CHAR/LOAD_CODE: aborts the load; `idx` clears, state LOAD_CHAR, no done pulse.
- ERROR:
  - `io_out[9]` is held at 1 and all input is ignored except flush.
  - Flush clears error, `idx`, `shreg`, `len` and table_ready, and goes to LOAD_CHAR with no done pulse.
- `io_in[11] == 0`: no state change and no pulses.

## Timing

- All outputs are registered.
- Reset value:
  - `io_out = 12'h000`.
  - State LOAD_CHAR; `idx`, `shreg` and `len` = 0.
  - Table contents don't-care.
- Reset takes priority over every input. Reset mid-decode discards the table and any partial code.
- Latency: a word sampled at edge N drives its effects on `io_out` from edge N until edge N+1.
  - The char valid and done pulses last exactly one cycle.
  - `io_out[7:0]` holds the last decoded character until the next match.
  - table_ready is set at the edge that accepts the last code word.
  - error is set at the edge that samples the offending word.
- Throughput: one bit per cycle; back-to-back matches produce back-to-back pulses.
- No backpressure: the decoder accepts every valid word.

## Test plan

- **Load and decode.**
  - Stimulus:
    - Load 0x861, 0xA11 (a = "1").
    - Load 0x86E, 0xA31 (n = "01").
    - Load 0x86D, 0xA30 (m = "00").
    - Then bits 0xC01, 0xC00, 0xC01, 0xC00, 0xC00, then 0xE00.
  - Required response:
    - table_ready after the 6th word.
    - `io_out` = 0x561 after the 1st bit, 0x56E after the 3rd, 0x56D after the 5th; 0x4xx with `[8] = 0` on the other bit cycles.
    - After flush: `io_out[11]` pulses and table_ready = 0.
- **No-match error.**
  - Stimulus:
    - Table a = 0xA11, n = 0xA31, m = 0xA71 ("001").
    - Bits 0, 0, 0, 0.
  - Required response: `io_out[9]` rises after the 4th bit, with no `[8]` pulse.
  - Then 0xE00 clears the error and `io_out` = 0x000.
- **Protocol error.** 0xA11 as the first word after reset gives `io_out[9] = 1` the next cycle; 0xC01 is then ignored while in ERROR.
- **Illegal mask.** Code word 0xA51 (mask 0101) gives an error.
- **Partial flush.** After a valid load, bit 0 then 0xE00 gives an error, not done.
- **Reset mid-decode.** Assert reset after one bit: `io_out` = 0x000 next cycle. A reload plus bit 1 then yields 0x561, with no stale `shreg` bits.

Source files
------------

// File: rtl/huff_decoder.sv
`default_nettype none
// ============================================================================
// Module : huff_decoder
// Loads a mask/value Huffman code table over the pin bus, then decodes a
// serial bitstream into one-cycle character strobes.
// Rev    : 1.0
// ============================================================================
module huff_decoder #(
  parameter int MAX_CHAR_COUNT = 3,
  parameter int CODE_W         = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [11:0] io_in,
  output logic [11:0] io_out
);

  localparam int c_IDX_W = (MAX_CHAR_COUNT > 1) ? $clog2(MAX_CHAR_COUNT) : 1;
  localparam int c_LEN_W = $clog2(CODE_W + 1);
  localparam logic [c_IDX_W-1:0] c_IDX_LAST  = c_IDX_W'(MAX_CHAR_COUNT - 1);
  localparam logic [c_IDX_W-1:0] c_IDX_ONE   = c_IDX_W'(1);
  localparam logic [c_LEN_W-1:0] c_LEN_FULL  = c_LEN_W'(CODE_W);
  localparam logic [c_LEN_W-1:0] c_LEN_ONE   = c_LEN_W'(1);
  localparam logic [CODE_W-1:0]  c_MASK_ONE  = CODE_W'(1);
  localparam logic [1:0]         c_CMD_CHAR  = 2'b00;
  localparam logic [1:0]         c_CMD_CODE  = 2'b01;
  localparam logic [1:0]         c_CMD_BIT   = 2'b10;
  localparam logic [1:0]         c_CMD_FLUSH = 2'b11;

  typedef enum logic [1:0] {
    ST_LOAD_CHAR = 2'd0,
    ST_LOAD_CODE = 2'd1,
    ST_DECODE    = 2'd2,
    ST_ERROR     = 2'd3
  } state_t;

  state_t               r_state, w_state_nxt;
  logic [c_IDX_W-1:0]   r_idx, w_idx_nxt;
  logic [CODE_W-1:0]    r_shreg, w_shreg_nxt;
  logic [c_LEN_W-1:0]   r_len, w_len_nxt;
  logic [7:0]           r_out_char, w_out_char_nxt;
  logic                 r_char_vld, w_char_vld_nxt;
  logic                 r_done, w_done_nxt;
  logic                 r_ready, w_ready_nxt;
  logic                 r_err, w_err_nxt;
  logic                 w_char_we, w_code_we;

  logic [7:0]           r_char [MAX_CHAR_COUNT];
  logic [CODE_W-1:0]    r_mask [MAX_CHAR_COUNT];
  logic [CODE_W-1:0]    r_val  [MAX_CHAR_COUNT];

  logic                 w_valid;
  logic [1:0]           w_cmd;
  logic [CODE_W-1:0]    w_mask_in, w_val_in;
  logic                 w_mask_legal;
  logic [CODE_W-1:0]    w_shreg_sh;
  logic [c_LEN_W-1:0]   w_len_sh;
  logic                 w_hit;
  logic [7:0]           w_hit_char;
  logic                 w_unused;

  function automatic logic [c_LEN_W-1:0] popcount(input logic [CODE_W-1:0] m);
    logic [c_LEN_W-1:0] cnt;
    cnt = '0;
    for (int i = 0; i < CODE_W; i++) begin
      if (m[i]) cnt = cnt + c_LEN_ONE;
    end
    return cnt;
  endfunction

  assign w_valid      = io_in[11];
  assign w_cmd        = io_in[10:9];
  assign w_mask_in    = io_in[2*CODE_W-1:CODE_W];
  assign w_val_in     = io_in[CODE_W-1:0];
  // A thermometer mask plus one has no bits in common with the mask itself.
  assign w_mask_legal = (w_mask_in != '0) && ((w_mask_in & (w_mask_in + c_MASK_ONE)) == '0);
  assign w_shreg_sh   = {r_shreg[CODE_W-2:0], io_in[0]};
  assign w_len_sh     = r_len + c_LEN_ONE;
  assign w_unused     = ^{io_in[8], r_shreg[CODE_W-1]};

  // Scan high to low so the lowest matching entry is the one left standing.
  always_comb begin
    w_hit      = 1'b0;
    w_hit_char = '0;
    for (int k = MAX_CHAR_COUNT - 1; k >= 0; k--) begin
      if ((w_len_sh == popcount(r_mask[k])) && ((w_shreg_sh & r_mask[k]) == r_val[k])) begin
        w_hit      = 1'b1;
        w_hit_char = r_char[k];
      end
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_idx_nxt      = r_idx;
    w_shreg_nxt    = r_shreg;
    w_len_nxt      = r_len;
    w_out_char_nxt = r_out_char;
    w_char_vld_nxt = 1'b0;
    w_done_nxt     = 1'b0;
    w_ready_nxt    = r_ready;
    w_err_nxt      = r_err;
    w_char_we      = 1'b0;
    w_code_we      = 1'b0;
    if (w_valid) begin
      case (r_state)
        ST_LOAD_CHAR: begin
          if (w_cmd == c_CMD_CHAR) begin
            w_char_we   = 1'b1;
            w_state_nxt = ST_LOAD_CODE;
          end else if (w_cmd == c_CMD_FLUSH) begin
            w_idx_nxt   = '0;
            w_state_nxt = ST_LOAD_CHAR;
          end else begin
            w_err_nxt   = 1'b1;
            w_state_nxt = ST_ERROR;
          end
        end
        ST_LOAD_CODE: begin
          if (w_cmd == c_CMD_CODE && w_mask_legal) begin
            w_code_we = 1'b1;
            if (r_idx == c_IDX_LAST) begin
              w_idx_nxt   = '0;
              w_ready_nxt = 1'b1;
              w_state_nxt = ST_DECODE;
            end else begin
              w_idx_nxt   = r_idx + c_IDX_ONE;
              w_state_nxt = ST_LOAD_CHAR;
            end
          end else if (w_cmd == c_CMD_FLUSH) begin
            w_idx_nxt   = '0;
            w_state_nxt = ST_LOAD_CHAR;
          end else begin
            w_err_nxt   = 1'b1;
            w_state_nxt = ST_ERROR;
          end
        end
        ST_DECODE: begin
          if (w_cmd == c_CMD_BIT) begin
            if (w_hit) begin
              w_out_char_nxt = w_hit_char;
              w_char_vld_nxt = 1'b1;
              w_shreg_nxt    = '0;
              w_len_nxt      = '0;
            end else if (w_len_sh == c_LEN_FULL) begin
              w_err_nxt   = 1'b1;
              w_state_nxt = ST_ERROR;
            end else begin
              w_shreg_nxt = w_shreg_sh;
              w_len_nxt   = w_len_sh;
            end
          end else if (w_cmd == c_CMD_FLUSH && r_len == '0) begin
            w_done_nxt  = 1'b1;
            w_ready_nxt = 1'b0;
            w_state_nxt = ST_LOAD_CHAR;
          end else begin
            w_err_nxt   = 1'b1;
            w_state_nxt = ST_ERROR;
          end
        end
        default: begin
          if (w_cmd == c_CMD_FLUSH) begin
            w_err_nxt   = 1'b0;
            w_idx_nxt   = '0;
            w_shreg_nxt = '0;
            w_len_nxt   = '0;
            w_ready_nxt = 1'b0;
            w_state_nxt = ST_LOAD_CHAR;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_LOAD_CHAR;
      r_idx      <= '0;
      r_shreg    <= '0;
      r_len      <= '0;
      r_out_char <= '0;
      r_char_vld <= 1'b0;
      r_done     <= 1'b0;
      r_ready    <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_idx      <= w_idx_nxt;
      r_shreg    <= w_shreg_nxt;
      r_len      <= w_len_nxt;
      r_out_char <= w_out_char_nxt;
      r_char_vld <= w_char_vld_nxt;
      r_done     <= w_done_nxt;
      r_ready    <= w_ready_nxt;
      r_err      <= w_err_nxt;
    end
  end

  // Table contents need no reset; table_ready gates their use.
  always_ff @(posedge clk) begin
    for (int k = 0; k < MAX_CHAR_COUNT; k++) begin
      if (w_char_we && r_idx == c_IDX_W'(k)) r_char[k] <= io_in[7:0];
      if (w_code_we && r_idx == c_IDX_W'(k)) begin
        r_mask[k] <= w_mask_in;
        r_val[k]  <= w_val_in;
      end
    end
  end

  assign io_out = {r_done, r_ready, r_err, r_char_vld, r_out_char};

endmodule
`default_nettype wire

// File: tb/tb_huff_decoder.sv
`default_nettype none
// ============================================================================
// Module : tb_huff_decoder
// Directed and randomized checks of huff_decoder against a behavioural model.
// Rev    : 1.0
// ============================================================================
module tb_huff_decoder;

  logic        clk;
  logic        reset;
  logic [11:0] io_in;
  logic [11:0] io_out;

  int vectors;
  int miscompares;

  huff_decoder #(.MAX_CHAR_COUNT(3), .CODE_W(4)) dut (
    .clk   (clk),
    .reset (reset),
    .io_in (io_in),
    .io_out(io_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: table as (char, code length, code value) triples and the
  // pending code as an integer of m_nbits bits.
  logic [7:0] t_char [3];
  int         t_len  [3];
  int         t_val  [3];
  int         m_words;
  bit         m_ready, m_err, m_cv, m_done;
  int         m_acc, m_nbits;
  logic [7:0] m_char;

  function automatic void model_reset();
    m_words = 0; m_ready = 0; m_err = 0; m_cv = 0; m_done = 0;
    m_acc = 0; m_nbits = 0; m_char = 8'h00;
  endfunction

  function automatic void model_step(input logic [11:0] w);
    logic [1:0] cmd;
    logic [3:0] mask;
    int         hit;
    cmd    = w[10:9];
    mask   = w[7:4];
    m_cv   = 0;
    m_done = 0;
    if (!w[11]) return;
    if (m_err) begin
      if (cmd == 2'b11) begin
        m_err = 0; m_ready = 0; m_words = 0; m_acc = 0; m_nbits = 0;
      end
      return;
    end
    if (!m_ready) begin
      if (cmd == 2'b11) m_words = 0;
      else if (m_words % 2 == 0) begin
        if (cmd == 2'b00) begin
          t_char[m_words / 2] = w[7:0];
          m_words++;
        end else m_err = 1;
      end else begin
        if (cmd == 2'b01 && (mask == 4'h1 || mask == 4'h3 || mask == 4'h7 || mask == 4'hF)) begin
          t_len[m_words / 2] = (mask == 4'h1) ? 1 : (mask == 4'h3) ? 2 : (mask == 4'h7) ? 3 : 4;
          t_val[m_words / 2] = int'(w[3:0]);
          m_words++;
          if (m_words == 6) begin
            m_ready = 1;
            m_words = 0;
          end
        end else m_err = 1;
      end
    end else begin
      if (cmd == 2'b10) begin
        m_acc = m_acc * 2 + int'(w[0]);
        m_nbits++;
        hit = -1;
        for (int k = 2; k >= 0; k--)
          if (t_len[k] == m_nbits && (m_acc % (1 << t_len[k])) == t_val[k]) hit = k;
        if (hit >= 0) begin
          m_char = t_char[hit]; m_cv = 1; m_acc = 0; m_nbits = 0;
        end else if (m_nbits == 4) m_err = 1;
      end else if (cmd == 2'b11 && m_nbits == 0) begin
        m_done = 1; m_ready = 0;
      end else m_err = 1;
    end
  endfunction

  task automatic check(input string tag, input logic [11:0] exp);
    vectors++;
    assert (io_out === exp) else begin
      miscompares++;
      $error("FAIL %s: io_out=%03h expected %03h", tag, io_out, exp);
    end
  endtask

  task automatic apply(input string tag, input logic [11:0] w);
    @(negedge clk);
    io_in = w;
    model_step(w);
    @(posedge clk);
    #1;
    check(tag, {m_done, m_ready, m_err, m_cv, m_char});
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    reset = 1'b1;
    io_in = 12'h000;
    @(posedge clk);
    #1;
    model_reset();
    check(tag, 12'h000);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic load_plan_table();
    apply("ld_c0", 12'h861); apply("ld_k0", 12'hA11);
    apply("ld_c1", 12'h86E); apply("ld_k1", 12'hA31);
    apply("ld_c2", 12'h86D); apply("ld_k2", 12'hA30);
  endtask

  initial begin
    logic [3:0] mask, val;
    logic [7:0] ch;
    int         len;
    vectors     = 0;
    miscompares = 0;
    reset       = 1'b1;
    io_in       = 12'h000;
    model_reset();
    repeat (2) @(posedge clk);
    do_reset("reset0");

    // Load and decode
    load_plan_table();
    check("ready_after_load", 12'h400);
    apply("bit1", 12'hC01); check("dec_a", 12'h561);
    apply("bit2", 12'hC00); check("hold_a", 12'h461);
    apply("bit3", 12'hC01); check("dec_n", 12'h56E);
    apply("bit4", 12'hC00);
    apply("bit5", 12'hC00); check("dec_m", 12'h56D);
    apply("flush", 12'hE00); check("done", 12'h86D);
    apply("idle", 12'h000); check("done_once", 12'h06D);

    // No-match error
    do_reset("reset1");
    apply("nm_c0", 12'h861); apply("nm_k0", 12'hA11);
    apply("nm_c1", 12'h86E); apply("nm_k1", 12'hA31);
    apply("nm_c2", 12'h86D); apply("nm_k2", 12'hA71);
    for (int i = 0; i < 4; i++) apply("nm_bit", 12'hC00);
    check("nomatch_err", 12'h600);
    apply("nm_flush", 12'hE00); check("nm_cleared", 12'h000);

    // Protocol error
    do_reset("reset2");
    apply("proto", 12'hA11); check("proto_err", 12'h200);
    apply("proto_ign", 12'hC01); check("proto_hold", 12'h200);
    apply("proto_flush", 12'hE00);

    // Illegal mask
    apply("im_c0", 12'h861);
    apply("im_k0", 12'hA51); check("illegal_mask", 12'h200);
    apply("im_flush", 12'hE00);

    // Partial flush
    load_plan_table();
    apply("pf_bit", 12'hC00);
    apply("pf_flush", 12'hE00); check("partial_flush", 12'h600);
    apply("pf_clear", 12'hE00);

    // Reset mid-decode
    load_plan_table();
    apply("rm_bit", 12'hC00);
    do_reset("reset_mid");
    load_plan_table();
    apply("rm_bit1", 12'hC01); check("no_stale", 12'h561);
    apply("rm_flush", 12'hE00);

    // Randomized tables and bitstreams
    for (int t = 0; t < 16; t++) begin
      apply("r_flush0", 12'hE00);
      apply("r_flush1", 12'hE00);
      for (int e = 0; e < 3; e++) begin
        ch  = 8'($urandom_range(8'h20, 8'h7E));
        len = $urandom_range(1, 4);
        mask = 4'((1 << len) - 1);
        if ($urandom_range(0, 9) == 0) mask = 4'($urandom);
        val = 4'($urandom_range(0, (1 << len) - 1));
        apply("r_char", {4'h8, ch});
        apply("r_code", {4'hA, mask, val});
      end
      for (int b = 0; b < 24; b++) begin
        if ($urandom_range(0, 7) == 0) apply("r_idle", {1'b0, 11'($urandom)});
        else apply("r_bit", {4'hC, 7'h00, 1'($urandom)});
      end
      apply("r_flush", 12'hE00);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
